// File: rtl/hue_sequencer.sv
// Purpose : colour-wheel duty generator; drives R/G/B pwm duty values 120 degrees apart over six hue sectors.
// Latency : outputs are registers that always equal the decode of the current (sector, ramp) state, so there is no lag.
// Backpressure: none; en=0 freezes all state and outputs. Optional HUE_REVERSE_EN macro adds a dir input for a reversed wheel.
module hue_sequencer #(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_CYCLES  = 1666,
  parameter int W            = $clog2(PWM_INTERVAL + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
`ifdef HUE_REVERSE_EN
  input  logic         dir,
`endif
  output logic [W-1:0] pwm_value_r,
  output logic [W-1:0] pwm_value_g,
  output logic [W-1:0] pwm_value_b,
  output logic [2:0]   sector,
  output logic         cycle_start
);

  // Prescaler needs at least one bit even when STEP_CYCLES==1 (it then stays at 0).
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [W-1:0]  FULL       = W'(PWM_INTERVAL);
  localparam logic [W-1:0]  RAMP_LAST  = W'(PWM_INTERVAL - 1);

  logic [PW-1:0] presc, presc_nxt;
  logic [W-1:0]  ramp, ramp_nxt;
  logic [2:0]    sector_nxt;
  logic          wrap;
  logic          ramp_step;
  logic [W-1:0]  r_nxt, g_nxt, b_nxt;
  logic [W-1:0]  up, dn;

  // Next-state: prescaler tick advances the ramp; ramp overflow/underflow moves the sector.
  always_comb begin
    presc_nxt  = presc;
    ramp_nxt   = ramp;
    sector_nxt = sector;
    wrap       = 1'b0;
    ramp_step  = (presc == PRESC_LAST);
    if (ramp_step) begin
      presc_nxt = '0;
    end else begin
      presc_nxt = presc + PW'(1);
    end
    if (ramp_step) begin
`ifdef HUE_REVERSE_EN
      if (dir) begin
        if (ramp == '0) begin
          ramp_nxt = RAMP_LAST;
          if (sector == 3'd0) begin
            sector_nxt = 3'd5;
            wrap       = 1'b1;
          end else begin
            sector_nxt = sector - 3'd1;
          end
        end else begin
          ramp_nxt = ramp - W'(1);
        end
      end else
`endif
      begin
        if (ramp == RAMP_LAST) begin
          ramp_nxt = '0;
          if (sector == 3'd5) begin
            sector_nxt = 3'd0;
            wrap       = 1'b1;
          end else begin
            sector_nxt = sector + 3'd1;
          end
        end else begin
          ramp_nxt = ramp + W'(1);
        end
      end
    end
  end

  // Duty decode of the next state so the registered outputs line up with the registered state.
  // ramp never reaches PWM_INTERVAL, so dn cannot underflow.
  always_comb begin
    up    = ramp_nxt;
    dn    = FULL - ramp_nxt;
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    case (sector_nxt)
      3'd0: begin r_nxt = FULL; g_nxt = up;   b_nxt = '0;   end
      3'd1: begin r_nxt = dn;   g_nxt = FULL; b_nxt = '0;   end
      3'd2: begin r_nxt = '0;   g_nxt = FULL; b_nxt = up;   end
      3'd3: begin r_nxt = '0;   g_nxt = dn;   b_nxt = FULL; end
      3'd4: begin r_nxt = up;   g_nxt = '0;   b_nxt = FULL; end
      3'd5: begin r_nxt = FULL; g_nxt = '0;   b_nxt = dn;   end
      default: begin r_nxt = '0; g_nxt = '0;  b_nxt = '0;   end
    endcase
  end

  // State and output registers; en=0 holds everything and suppresses the wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      ramp        <= '0;
      sector      <= 3'd0;
      cycle_start <= 1'b0;
      pwm_value_r <= FULL;
      pwm_value_g <= '0;
      pwm_value_b <= '0;
    end else if (en) begin
      presc       <= presc_nxt;
      ramp        <= ramp_nxt;
      sector      <= sector_nxt;
      cycle_start <= wrap;
      pwm_value_r <= r_nxt;
      pwm_value_g <= g_nxt;
      pwm_value_b <= b_nxt;
    end else begin
      cycle_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hue_sequencer.sv
// Bench for hue_sequencer: two instances (STEP_CYCLES=2 and 1, PWM_INTERVAL=8) share clock, reset and enable.
// Stimulus pushes expected state per clock into queues; a negedge monitor pops and compares, plus per-step delta checks.
// Directed spot checks cover reset, first step, sector boundaries, wrap pulses, enable hold and async mid-sector reset.
module tb_hue_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
`ifdef HUE_REVERSE_EN
  logic       dir;
`endif
  logic [3:0] ra, ga, ba, rb, gb, bb;
  logic [2:0] sa, sb;
  logic       csa, csb;

  typedef struct {
    int r;
    int g;
    int b;
    int sec;
    int cs;
    bit first;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int errors = 0;
  int checks = 0;
  int n;
  bit first;

  hue_sequencer #(.PWM_INTERVAL(8), .STEP_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef HUE_REVERSE_EN
    .dir(dir),
`endif
    .pwm_value_r(ra), .pwm_value_g(ga), .pwm_value_b(ba),
    .sector(sa), .cycle_start(csa)
  );

  hue_sequencer #(.PWM_INTERVAL(8), .STEP_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef HUE_REVERSE_EN
    .dir(dir),
`endif
    .pwm_value_r(rb), .pwm_value_g(gb), .pwm_value_b(bb),
    .sector(sb), .cycle_start(csb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (enabled clocks=%0d)", name, act, req, n);
    end
  endtask

  // Reference: position derived from the count of enabled clocks since reset.
  function automatic exp_t model(input int cnt, input int s, input int cs, input bit fst);
    exp_t e;
    int steps;
    int rp;
    steps   = cnt / s;
    rp      = steps % 8;
    e.sec   = (steps / 8) % 6;
    e.cs    = cs;
    e.first = fst;
    case (e.sec)
      0: begin e.r = 8;      e.g = rp;     e.b = 0;      end
      1: begin e.r = 8 - rp; e.g = 8;      e.b = 0;      end
      2: begin e.r = 0;      e.g = 8;      e.b = rp;     end
      3: begin e.r = 0;      e.g = 8 - rp; e.b = 8;      end
      4: begin e.r = rp;     e.g = 0;      e.b = 8;      end
      default: begin e.r = 8; e.g = 0;     e.b = 8 - rp; end
    endcase
    return e;
  endfunction

  task automatic step(input logic e);
    @(negedge clk);
    en = e;
    @(posedge clk);
    #1;
    if (e) n++;
    qa.push_back(model(n, 2, (e && n > 0 && n % 96 == 0) ? 1 : 0, first));
    qb.push_back(model(n, 1, (e && n > 0 && n % 48 == 0) ? 1 : 0, first));
    first = 1'b0;
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Monitor: compare every clock's outputs against the queued expectations.
  initial begin
    exp_t ea, eb;
    int par, pag, pab, pbr, pbg, pbb;
    par = 8; pag = 0; pab = 0; pbr = 8; pbg = 0; pbb = 0;
    forever begin
      @(negedge clk);
      if (qa.size() > 0 && qb.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_r", int'(ra), ea.r);
        chk("a_g", int'(ga), ea.g);
        chk("a_b", int'(ba), ea.b);
        chk("a_sector", int'(sa), ea.sec);
        chk("a_cycle_start", int'(csa), ea.cs);
        chk("b_r", int'(rb), eb.r);
        chk("b_g", int'(gb), eb.g);
        chk("b_b", int'(bb), eb.b);
        chk("b_sector", int'(sb), eb.sec);
        chk("b_cycle_start", int'(csb), eb.cs);
        if (!ea.first) begin
          chk("a_delta_r_le1", (absd(int'(ra), par) <= 1) ? 1 : 0, 1);
          chk("a_delta_g_le1", (absd(int'(ga), pag) <= 1) ? 1 : 0, 1);
          chk("a_delta_b_le1", (absd(int'(ba), pab) <= 1) ? 1 : 0, 1);
          chk("b_delta_r_le1", (absd(int'(rb), pbr) <= 1) ? 1 : 0, 1);
          chk("b_delta_g_le1", (absd(int'(gb), pbg) <= 1) ? 1 : 0, 1);
          chk("b_delta_b_le1", (absd(int'(bb), pbb) <= 1) ? 1 : 0, 1);
        end
        par = int'(ra); pag = int'(ga); pab = int'(ba);
        pbr = int'(rb); pbg = int'(gb); pbb = int'(bb);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
`ifdef HUE_REVERSE_EN
    dir   = 1'b0;
`endif
    n     = 0;
    first = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_r", int'(ra), 8);
    chk("reset_g", int'(ga), 0);
    chk("reset_b", int'(ba), 0);
    chk("reset_sector", int'(sa), 0);
    chk("reset_cycle_start", int'(csa), 0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1);
    chk("first_clock_g", int'(ga), 0);
    step(1'b1);
    chk("first_step_g", int'(ga), 1);

    // One full cycle for the STEP_CYCLES=2 instance (two for STEP_CYCLES=1).
    while (n < 96) begin
      step(1'b1);
      if (n == 14) chk("end_sector0_g", int'(ga), 7);
      if (n == 16) begin
        chk("sector1_entry_sector", int'(sa), 1);
        chk("sector1_entry_r", int'(ra), 8);
        chk("sector1_entry_g", int'(ga), 8);
      end
      if (n == 48) chk("step1_cycle_start_48", int'(csb), 1);
      if (n == 94) begin
        chk("end_sector5_b", int'(ba), 1);
        chk("end_sector5_r", int'(ra), 8);
      end
      if (n == 96) begin
        chk("wrap_sector", int'(sa), 0);
        chk("wrap_b", int'(ba), 0);
        chk("wrap_r", int'(ra), 8);
        chk("wrap_cycle_start", int'(csa), 1);
      end
      if (n == 95) chk("no_early_pulse", int'(csa), 0);
    end

    // Enable hold at sector 2, ramp 3, prescaler mid-count.
    while (n < 135) step(1'b1);
    chk("hold_pre_sector", int'(sa), 2);
    chk("hold_pre_b", int'(ba), 3);
    repeat (10) step(1'b0);
    chk("hold_sector", int'(sa), 2);
    chk("hold_b", int'(ba), 3);
    chk("hold_cycle_start", int'(csa), 0);
    step(1'b1);
    chk("resume_b", int'(ba), 4);

    // Asynchronous reset in the middle of sector 3.
    while (n < 150) step(1'b1);
    chk("mid_sector3", int'(sa), 3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("async_reset_r", int'(ra), 8);
    chk("async_reset_g", int'(ga), 0);
    chk("async_reset_b", int'(ba), 0);
    chk("async_reset_sector", int'(sa), 0);
    chk("async_reset_cycle_start", int'(csa), 0);
    n     = 0;
    first = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    step(1'b1);
    chk("post_reset_first_step_g", int'(ga), 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
